rtdc_disp_scan: RTL
===================

Name: rtdc_disp_scan

Overview:
- Downstream stage of the RTDC real-time clock. Consumes the six 7-segment codes (HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L) and drives a time-multiplexed 6-digit display through one shared segment bus and six digit enables.
- Provides anti-ghost blanking between digits, frame-coherent snapshotting of the time, optional hour-tens leading-zero blanking, and a blinking colon.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot. Must be greater than BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all digits and segments off. 0 means no blanking.
- ACTIVE_LOW, 1: 1 inverts seg, dig_en and colon at the pins (common-anode). 0 drives them active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L  in  7 each  segment codes {g,f,e,d,c,b,a}, 1 means lit.
- lz_blank  in  1  1 blanks the HRM digit when it shows '0' (7'h3F).
- colon_tick  in  1  one-cycle pulse, once per second.
- seg  out  7  shared segment bus.
- dig_en  out  6  digit enables. Bit0 is SEC_L, bit5 is HRM.
- colon  out  1  colon LED.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Internal counters
  - cnt runs 0..SCAN_DIV-1. idx runs 0..5.
  - At cnt==SCAN_DIV-1: cnt goes to 0 and idx increments, wrapping 5 to 0.
  - Frame length is 6*SCAN_DIV cycles.
- Slot phases
  - cnt < BLANK_CYC is BLANK: all digits off, all segments off.
  - Otherwise SHOW: dig_en has only bit idx on; seg = shadow[idx].
- Snapshot
  - Six 7-bit shadow registers are loaded from the inputs on the last cycle of a frame (idx==5 and cnt==SCAN_DIV-1).
  - Input changes mid-frame are not visible until the next frame.
  - Shadows reset to 0, so the first frame after reset is dark.
- Leading zero: when lz_blank==1 and shadow[5]==7'h3F, slot 5 is treated as BLANK for the whole slot (dig_en bit5 stays off).
- Colon
  - Internal colon_r toggles on every colon_tick cycle. Reset value is 0 (off).
  - A tick in the same cycle as active reset is ignored.
- Output timing
  - All outputs are registered and computed from the current cnt, idx and shadows, giving one cycle of latency. All outputs are mutually aligned.
  - frame_start is high during the output cycle that corresponds to idx==0, cnt==0, i.e. the first BLANK cycle of slot 0.
- Polarity: when ACTIVE_LOW=1, seg, dig_en and colon are bitwise inverted after the logical value is formed. frame_start is never inverted.
- Reset (rst low, asynchronous)
  - cnt=0, idx=0, shadows=0, colon_r=0, frame_start=0.
  - seg, dig_en and colon take their off values: 7'h7F, 6'h3F, 1 for ACTIVE_LOW=1; all 0 for ACTIVE_LOW=0.
  - Reset mid-frame takes effect immediately, with no clock edge required.
  - After release, the first output cycle is slot 0 cnt 0 with frame_start=1.
- Invariants
  - Never more than one dig_en bit is active.
  - The segment bus is off whenever no digit is enabled.

Test Plan:
Bench uses SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1.
1. Assert rst=0 with no clock running -> seg=7'h7F, dig_en=6'h3F, colon=1, frame_start=0 immediately. Release rst -> frame_start high on the first output cycle, then every 48 cycles.
2. SEC_L=7'h06, all other inputs 7'h3F, wait one frame -> each slot shows 2 cycles of dig_en=6'h3F, then 6 cycles of the active digit:
   - slot 0: dig_en=6'h3E, seg=7'h79.
   - slot 1: dig_en=6'h3D, seg=7'h40.
3. Change SEC_L from 7'h06 to 7'h5B while idx==2 -> slot 0 keeps showing seg=7'h79 until the frame after the next snapshot, then shows seg=7'h24.
4. HRM=7'h3F:
   - lz_blank=1 -> dig_en stays 6'h3F for all 8 cycles of slot 5.
   - lz_blank=0 -> dig_en=6'h1F, seg=7'h40 in the SHOW cycles of slot 5.
5. Three colon_tick pulses 10 cycles apart -> colon goes 1->0->1->0, each transition one cycle after its tick. A tick held for 1 cycle toggles exactly once.
6. Pull rst low at idx==3, cnt==5 -> all outputs return to reset values, shadows are cleared, and the next frame after release is fully dark.

Source files
------------

// File: rtl/rtdc_disp_scan.sv
// Time-multiplexed 6-digit 7-segment scanner for the RTDC clock.
// Time is latched once per frame, with anti-ghost blanking, hour-tens zero blanking and a blinking colon.
module rtdc_disp_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] HRM,
    input  logic [6:0] HRL,
    input  logic [6:0] MIN_M,
    input  logic [6:0] MIN_L,
    input  logic [6:0] SEC_M,
    input  logic [6:0] SEC_L,
    input  logic       lz_blank,
    input  logic       colon_tick,
    output logic [6:0] seg,
    output logic [5:0] dig_en,
    output logic       colon,
    output logic       frame_start
);

    localparam int             CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [2:0]     IDX_LAST  = 3'd5;
    localparam logic [6:0]     ZERO_CODE = 7'h3F;
    // Off levels double as the XOR masks that apply pin polarity.
    localparam logic [6:0]     SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [5:0]     DIG_OFF   = {6{ACTIVE_LOW}};
    localparam logic           COLON_OFF = ACTIVE_LOW;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [6:0]       shadow_r [6];
    logic             colon_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_nxt_s;
    logic             slot_end_s;
    logic             frame_end_s;
    logic [6:0]       cur_code_s;
    logic [5:0]       dig_sel_s;
    logic             lz_hide_s;
    phase_t           phase_s;
    logic [6:0]       seg_log_s;
    logic [5:0]       dig_log_s;
    logic             colon_nxt_s;
    logic             frame_first_s;

    // Slot counter and digit index next-state.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        slot_end_s  = (cnt_r == CNT_LAST);
        frame_end_s = slot_end_s && (idx_r == IDX_LAST);
        if (slot_end_s) begin
            cnt_nxt_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = 3'd0;
            end else begin
                idx_nxt_s = idx_r + 3'd1;
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            idx_nxt_s = idx_r;
        end
    end

    // Slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Frame-coherent snapshot of the time, taken on the last cycle of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= 7'h00;
            end
        end else if (frame_end_s) begin
            shadow_r[0] <= SEC_L;
            shadow_r[1] <= SEC_M;
            shadow_r[2] <= MIN_L;
            shadow_r[3] <= MIN_M;
            shadow_r[4] <= HRL;
            shadow_r[5] <= HRM;
        end
    end

    // Digit select and code for the current slot.
    always_comb begin
        cur_code_s = 7'h00;
        dig_sel_s  = 6'b000000;
        case (idx_r)
            3'd0: begin cur_code_s = shadow_r[0]; dig_sel_s = 6'b000001; end
            3'd1: begin cur_code_s = shadow_r[1]; dig_sel_s = 6'b000010; end
            3'd2: begin cur_code_s = shadow_r[2]; dig_sel_s = 6'b000100; end
            3'd3: begin cur_code_s = shadow_r[3]; dig_sel_s = 6'b001000; end
            3'd4: begin cur_code_s = shadow_r[4]; dig_sel_s = 6'b010000; end
            3'd5: begin cur_code_s = shadow_r[5]; dig_sel_s = 6'b100000; end
            default: begin cur_code_s = 7'h00; dig_sel_s = 6'b000000; end
        endcase
    end

    // Phase decode: the hour-tens zero blanks the entire slot, not just its SHOW part.
    always_comb begin
        phase_s       = PH_SHOW;
        seg_log_s     = 7'h00;
        dig_log_s     = 6'b000000;
        lz_hide_s     = lz_blank && (idx_r == IDX_LAST) && (shadow_r[5] == ZERO_CODE);
        frame_first_s = (idx_r == 3'd0) && (cnt_r == '0);
        if ((cnt_r < CNT_BLANK) || lz_hide_s || (dig_sel_s == 6'b000000)) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_SHOW;
        end
        case (phase_s)
            PH_SHOW: begin
                seg_log_s = cur_code_s;
                dig_log_s = dig_sel_s;
            end
            PH_BLANK: begin
                seg_log_s = 7'h00;
                dig_log_s = 6'b000000;
            end
            default: begin
                seg_log_s = 7'h00;
                dig_log_s = 6'b000000;
            end
        endcase
    end

    // Colon toggle; the pin follows the toggled value so it moves one cycle after the tick.
    always_comb begin
        colon_nxt_s = colon_r ^ colon_tick;
    end

    // Colon state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colon_r <= 1'b0;
        end else begin
            colon_r <= colon_nxt_s;
        end
    end

    // Registered, polarity-adjusted pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg         <= SEG_OFF;
            dig_en      <= DIG_OFF;
            colon       <= COLON_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_log_s ^ SEG_OFF;
            dig_en      <= dig_log_s ^ DIG_OFF;
            colon       <= colon_nxt_s ^ COLON_OFF;
            frame_start <= frame_first_s;
        end
    end

endmodule
